// File: rtl/saturn_debug_pkg.sv
// Shared definitions for the saturn debug UART path.
//  - uart_state_t : transmitter FSM encodings (IDLE=0, START=1, DATA=2, STOP=3)
//  - UART_DATA_BITS : data bits per 8N1 frame
//  - clks_per_bit() : clock cycles per UART bit (integer divide)
package saturn_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/saturn_char_fifo.sv
// Synchronous byte FIFO for the debug UART.
// Ports:
//  clk, reset      clock / synchronous active-high reset
//  push_data[7:0]  byte written at the tail when push is accepted
//  push            write request, ignored while full
//  pop             read request, ignored while empty
//  pop_data[7:0]   current head byte (valid whenever !empty)
//  full, empty     registered occupancy flags
module saturn_char_fifo
    import saturn_debug_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] push_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0] rd_ptr_reg, rd_ptr_next;
    logic                full_reg, empty_reg;
    logic                push_ok, pop_ok;
    logic [7:0]          mem [DEPTH];

    // Flags are the registered pre-edge view: a push is refused while full
    // even if a pop frees a slot on the same edge.
    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            // Extra pointer MSB distinguishes full from empty.
            full_reg   <= (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                          (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);
            empty_reg  <= (wr_ptr_next == rd_ptr_next);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= push_data;
    end

    // Head is presented combinationally so the transmitter can load it into
    // its shifter on the same edge it pops.
    assign pop_data = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
    assign full     = full_reg;
    assign empty    = empty_reg;

endmodule

// File: rtl/saturn_debug_uart_tx.sv
// Debug character sink: buffers bus-strobed bytes and sends them as 8N1 frames.
// Ports:
//  clk, reset            clock / synchronous active-high reset
//  i_char_to_send[7:0]   byte to enqueue
//  i_char_valid          enqueue strobe, one byte per high cycle
//  o_serial_tx           UART line, idle high, registered
//  o_serial_busy         FIFO non-empty or frame still in progress
//  o_fifo_full           FIFO holds 2**DEPTH_LOG2 bytes
//  o_char_counter[9:0]   frames completed (stop bit finished), wrapping
//  o_drop_count[7:0]     bytes refused while full, saturating at 255
module saturn_debug_uart_tx
    import saturn_debug_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_char_to_send,
    input  logic       i_char_valid,
    output logic       o_serial_tx,
    output logic       o_serial_busy,
    output logic       o_fifo_full,
    output logic [9:0] o_char_counter,
    output logic [7:0] o_drop_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t       state_reg, state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [9:0]        char_count_reg, char_count_next;
    logic [7:0]        drop_count_reg, drop_count_next;

    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_end;

    saturn_char_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_data (i_char_to_send),
        .push      (i_char_valid),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign baud_end = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            char_count_reg <= '0;
            drop_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            char_count_reg <= char_count_next;
            drop_count_reg <= drop_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        baud_cnt_next   = baud_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        tx_next         = 1'b1;
        done_next       = 1'b0;
        fifo_pop        = 1'b0;
        char_count_next = char_count_reg;
        drop_count_next = drop_count_reg;

        // The line level is registered from the current state, so the pin
        // trails the FSM by one clock throughout the frame.
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_head;
                    baud_cnt_next = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                tx_next = shift_reg[0];
                if (baud_end) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == BIT_LAST) state_next = ST_STOP;
                    else bit_idx_next = bit_idx_reg + 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    baud_cnt_next = '0;
                    state_next    = ST_IDLE;
                    done_next     = 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // done_reg carries the end-of-frame event one clock later, in step
        // with the pin, so the count moves when the stop bit has finished on
        // the line and busy holds until then.
        if (done_reg) char_count_next = char_count_reg + 1'b1;

        if (i_char_valid && fifo_full && (drop_count_reg != 8'hFF))
            drop_count_next = drop_count_reg + 1'b1;

        busy_next = !fifo_empty || (state_reg != ST_IDLE) || done_reg;
    end

    assign o_serial_tx    = tx_reg;
    assign o_serial_busy  = busy_reg;
    assign o_fifo_full    = fifo_full;
    assign o_char_counter = char_count_reg;
    assign o_drop_count   = drop_count_reg;

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// Testbench for saturn_debug_uart_tx: randomized/directed pushes feed a
// queue-based reference model; a line monitor decodes UART frames and checks
// them against the expected-frame queue.
module tb_saturn_debug_uart_tx;

    localparam int CLK_HZ     = 1000000;
    localparam int BAUD       = 200000;
    localparam int DEPTH_LOG2 = 2;
    localparam int CPB        = CLK_HZ / BAUD;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int FRAME      = 10 * CPB + 1;

    logic       clk;
    logic       reset;
    logic [7:0] i_char_to_send;
    logic       i_char_valid;
    logic       o_serial_tx;
    logic       o_serial_busy;
    logic       o_fifo_full;
    logic [9:0] o_char_counter;
    logic [7:0] o_drop_count;

    saturn_debug_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_char_to_send (i_char_to_send),
        .i_char_valid   (i_char_valid),
        .o_serial_tx    (o_serial_tx),
        .o_serial_busy  (o_serial_busy),
        .o_fifo_full    (o_fifo_full),
        .o_char_counter (o_char_counter),
        .o_drop_count   (o_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic [7:0] m_fifo[$];
    int         m_done_edges[$];
    frame_t     exp_q[$];
    int         m_next_pop   = 0;
    int         m_last_done  = -1;
    int         m_last_pop   = 0;
    int         m_drops      = 0;
    int         m_chars      = 0;
    int         m_accepted   = 0;
    bit         m_busy       = 0;
    int         epoch        = 0;
    int         frames_seen  = 0;

    // Effect of clock edge e given the inputs presented before it.
    task automatic model_edge(input int e, input logic v, input logic [7:0] d, input logic r);
        bit     was_full;
        bit     nonempty;
        frame_t f;
        if (r) begin
            m_fifo.delete();
            exp_q.delete();
            m_done_edges.delete();
            m_next_pop  = 0;
            m_last_done = -1;
            m_drops     = 0;
            m_chars     = 0;
            m_accepted  = 0;
            m_busy      = 0;
            return;
        end
        was_full = (m_fifo.size() == DEPTH);
        nonempty = (m_fifo.size() != 0);
        m_busy   = nonempty || (e <= m_last_done);
        if (m_done_edges.size() > 0 && m_done_edges[0] == e) begin
            void'(m_done_edges.pop_front());
            m_chars = (m_chars + 1) % 1024;
        end
        if (nonempty && e >= m_next_pop) begin
            f.data  = m_fifo.pop_front();
            f.start = e + 1;
            exp_q.push_back(f);
            m_last_pop  = e;
            m_next_pop  = e + FRAME;
            m_last_done = e + FRAME;
            m_done_edges.push_back(e + FRAME);
        end
        if (v) begin
            if (was_full) begin
                if (m_drops < 255) m_drops++;
            end else begin
                m_fifo.push_back(d);
                m_accepted++;
            end
        end
    endtask

    task automatic check_outputs();
        check("fifo_full", o_fifo_full, (m_fifo.size() == DEPTH) ? 1 : 0);
        check("drop_count", o_drop_count, m_drops);
        check("char_counter", o_char_counter, m_chars);
        check("busy", o_serial_busy, m_busy ? 1 : 0);
    endtask

    // Called at a negedge: present inputs, let one edge pass, compare.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
        i_char_valid   = v;
        i_char_to_send = d;
        reset          = r;
        if (r) epoch++;
        model_edge(cyc + 1, v, d, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_fifo.size() == 0 && exp_q.size() == 0 && cyc > m_last_done)) begin
            if (n >= 3000) begin
                checks_total++;
                $display("FAIL wait_idle: timeout, got %0d frames pending expected 0", exp_q.size());
                return;
            end
            drive_cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
    endtask

    // ---------------- line monitor ----------------
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        logic       prev;
        logic [7:0] b;
        logic       start_bit;
        logic       stop_bit;
        int         s;
        int         ep;
        frame_t     f;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && o_serial_tx === 1'b0 && reset === 1'b0) begin
                s  = cyc;
                ep = epoch;
                wait_until(s + CPB / 2);
                start_bit = o_serial_tx;
                for (int i = 0; i < 8; i++) begin
                    wait_until(s + CPB / 2 + CPB * (i + 1));
                    b[i] = o_serial_tx;
                end
                wait_until(s + CPB / 2 + CPB * 9);
                stop_bit = o_serial_tx;
                if (epoch == ep && reset === 1'b0) begin
                    frames_seen++;
                    check("start_bit", start_bit, 0);
                    check("stop_bit", stop_bit, 1);
                    if (exp_q.size() == 0) begin
                        checks_total++;
                        $display("FAIL unexpected_frame: got 0x%02h expected no frame (cycle %0d)", b, s);
                    end else begin
                        f = exp_q.pop_front();
                        check("frame_data", b, f.data);
                        check("frame_start", s, f.start);
                        $display("frame %0d: data 0x%02h (exp 0x%02h) start cycle %0d (exp %0d)",
                                 frames_seen, b, f.data, s, f.start);
                    end
                end
            end
            prev = o_serial_tx;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] burst4 [4];
        int         len;
        int         gap;
        int         guard;
        burst4[0] = 8'h55; burst4[1] = 8'hAA; burst4[2] = 8'h00; burst4[3] = 8'hFF;
        i_char_valid   = 1'b0;
        i_char_to_send = 8'h00;
        reset          = 1'b1;
        @(negedge clk);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b1);
        check("reset_tx", o_serial_tx, 1);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);

        // Single byte: latency and framing.
        drive_cycle(1'b1, 8'h41, 1'b0);
        wait_idle();
        check("single_count", o_char_counter, 1);

        // Four consecutive pushes: head is popped early, so never full.
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, burst4[i], 1'b0);
        check("burst4_not_full", o_fifo_full, 0);
        wait_idle();

        // Six consecutive pushes: exactly one is refused.
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
        check("burst6_drop", o_drop_count, 1);
        wait_idle();

        // Hold valid for 300 cycles: drop count saturates.
        repeat (300) drive_cycle(1'b1, 8'h5A, 1'b0);
        check("drop_saturate", o_drop_count, 255);
        wait_idle();

        // Reset in the middle of the data bits of 0xC3.
        drive_cycle(1'b1, 8'hC3, 1'b0);
        guard = 0;
        while (cyc < m_last_pop + 1 + 3 * CPB && guard < 200) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            guard++;
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        check("reset_mid_tx", o_serial_tx, 1);
        repeat (2) drive_cycle(1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'h31, 1'b0);
        wait_idle();
        check("after_reset_count", o_char_counter, 1);

        // Random bursts with random gaps.
        for (int k = 0; k < 15; k++) begin
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) drive_cycle(1'b1, 8'($urandom), 1'b0);
            gap = $urandom_range(0, 120);
            repeat (gap) drive_cycle(1'b0, 8'h00, 1'b0);
        end
        wait_idle();

        // Counter wrap: 1030 frames after a reset.
        drive_cycle(1'b0, 8'h00, 1'b1);
        guard = 0;
        while (m_accepted < 1030 && guard < 70000) begin
            drive_cycle((m_fifo.size() < DEPTH) ? 1'b1 : 1'b0, 8'($urandom), 1'b0);
            guard++;
        end
        wait_idle();
        check("wrap_count", o_char_counter, 6);
        check("leftover_frames", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
